// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: FSM encoding and a width helper.
package edge_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // Smallest width able to index 'value' entries (at least 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/negedge_sync_cell.sv
// Synchroniser chain plus falling-edge detector for one asynchronous event line.
module negedge_sync_cell #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Zero on reset, so a line held low across reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_event_arbiter.sv
// Queues falling edges from N async lines and hands them out round-robin over valid/ready.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned IDW         = clog2(N),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   I,
    input  logic [N-1:0]   en,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [IDW-1:0] ev_id,
    output logic           ev_ovf,
    output logic           busy
);

    logic [N-1:0]   fall;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic           ev_valid_q, ev_valid_d;
    logic [IDW-1:0] ev_id_q, ev_id_d;
    logic           ev_ovf_q, ev_ovf_d;

    logic           handshake;
    logic           load;
    logic [N-1:0]   load_mask;
    logic [N-1:0]   eligible;
    logic [IDW-1:0] base;
    logic [IDW-1:0] start;
    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rotated;
    logic [IDW-1:0] offset;
    logic [IDW-1:0] winner;
    logic           found;

    for (genvar g = 0; g < N; g++) begin : g_cell
        negedge_sync_cell #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .line (I[g]),
            .fall (fall[g])
        );
    end

    assign handshake = ev_valid_q & ev_ready;
    // A disabled channel is never granted, even if its bit is still set this cycle.
    assign eligible  = pending_q & en;
    // On a handshake the just-granted id becomes the new rotation origin immediately.
    assign base      = handshake ? ev_id_q : last_grant_q;

    // Rotate so the channel after 'base' sits at bit 0, then find the first set bit.
    always_comb begin
        start   = IDW'((32'(base) + 32'd1) % N);
        doubled = {eligible, eligible};
        shifted = doubled >> start;
        rotated = shifted[N-1:0];
        found   = 1'b0;
        offset  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = IDW'(k);
            end
        end
        winner = IDW'((32'(start) + 32'(offset)) % N);
    end

    assign load      = found & ((state_q == ST_IDLE) | handshake);
    assign load_mask = load ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ev_valid_d   = ev_valid_q;
        ev_id_d      = ev_id_q;
        ev_ovf_d     = ev_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_OFFER;
                    ev_valid_d = 1'b1;
                    ev_id_d    = winner;
                    ev_ovf_d   = ovf_q[winner];
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    last_grant_d = ev_id_q;
                    if (found) begin
                        ev_id_d  = winner;
                        ev_ovf_d = ovf_q[winner];
                    end else begin
                        state_d    = ST_IDLE;
                        ev_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ev_valid_d = 1'b0;
            end
        endcase
    end

    // A new fall on the channel being loaded starts a fresh pending event with no overflow.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < N; i++) begin
            if (!en[i]) begin
                pending_d[i] = 1'b0;
                ovf_d[i]     = 1'b0;
            end else if (fall[i] && pending_q[i] && !load_mask[i]) begin
                ovf_d[i] = 1'b1;
            end else if (fall[i]) begin
                pending_d[i] = 1'b1;
                ovf_d[i]     = 1'b0;
            end else if (load_mask[i]) begin
                pending_d[i] = 1'b0;
                ovf_d[i]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q    <= '0;
            ovf_q        <= '0;
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(N - 1);
            ev_valid_q   <= 1'b0;
            ev_id_q      <= '0;
            ev_ovf_q     <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ev_valid_q   <= ev_valid_d;
            ev_id_q      <= ev_id_d;
            ev_ovf_q     <= ev_ovf_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign ev_ovf   = ev_ovf_q;
    assign busy     = (|pending_q) | ev_valid_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int SYNC = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   lines;
    logic [N-1:0]   en;
    logic           ev_valid;
    logic           ev_ready;
    logic [IDW-1:0] ev_id;
    logic           ev_ovf;
    logic           busy;

    int    n_compared;
    int    n_mismatched;
    string phase;

    edge_event_arbiter #(
        .N          (N),
        .IDW        (IDW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .I       (lines),
        .en      (en),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_id   (ev_id),
        .ev_ovf  (ev_ovf),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a delay line of sampled line words, a pending set and an offer slot.
    logic [N-1:0] m_pipe[$];
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    bit           m_valid;
    bit           m_eovf;
    int           m_id;
    int           m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s/%s: got %0d, expected %0d at t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 0;
        m_eovf  = 0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    task automatic model_step();
        logic [N-1:0] fall;
        logic [N-1:0] elig;
        logic [N-1:0] np;
        logic [N-1:0] no;
        bit           hs;
        bit           found;
        bit           ld;
        int           origin;
        int           w;
        if (!reset) begin
            model_reset();
        end else begin
            fall  = m_prev & ~m_pipe[SYNC-1];
            elig  = m_pend & en;
            hs    = m_valid && ev_ready;
            found = 0;
            w     = 0;
            if (!m_valid || hs) begin
                origin = hs ? m_id : m_last;
                for (int k = 1; k <= N; k++) begin
                    if (!found && elig[(origin + k) % N]) begin
                        found = 1;
                        w     = (origin + k) % N;
                    end
                end
            end
            np = m_pend;
            no = m_ovf;
            for (int i = 0; i < N; i++) begin
                ld = found && (w == i);
                if (!en[i]) begin
                    np[i] = 0;
                    no[i] = 0;
                end else if (fall[i] && m_pend[i] && !ld) begin
                    no[i] = 1;
                end else if (fall[i]) begin
                    np[i] = 1;
                    no[i] = 0;
                end else if (ld) begin
                    np[i] = 0;
                    no[i] = 0;
                end
            end
            if (hs) m_last = m_id;
            if (found) begin
                m_valid = 1;
                m_id    = w;
                m_eovf  = m_ovf[w];
            end else if (hs) begin
                m_valid = 0;
            end
            m_pend = np;
            m_ovf  = no;
            m_prev = m_pipe[SYNC-1];
            m_pipe.push_front(lines);
            void'(m_pipe.pop_back());
        end
    endtask

    task automatic compare_model();
        check_eq("valid", 32'(ev_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'((|m_pend) || m_valid));
        if (m_valid) begin
            check_eq("id", 32'(ev_id), 32'(m_id));
            check_eq("ovf", 32'(ev_ovf), 32'(m_eovf));
        end
    endtask

    // Inputs change at the negedge; the model advances on the same posedge as the DUT.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    int got_ids[$];
    int got_ovfs[$];

    task automatic collect(input int n);
        got_ids.delete();
        got_ovfs.delete();
        for (int c = 0; c < n; c++) begin
            if (ev_valid && ev_ready) begin
                got_ids.push_back(int'(ev_id));
                got_ovfs.push_back(int'(ev_ovf));
            end
            cycle();
        end
    endtask

    task automatic check_order(input string tag, input int e0, input int e1, input int e2,
                               input int e3);
        int exp_ids[4];
        exp_ids = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, 32'(got_ids.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_ids.size(); i++) begin
            check_eq(tag, 32'(got_ids[i]), 32'(exp_ids[i]));
        end
    endtask

    int first_seen;
    int valid_cycles;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();
        reset    = 1'b0;
        lines    = '0;
        en       = '1;
        ev_ready = 1'b0;

        phase = "reset_hold";
        run(3);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check_eq("no_valid", 32'(ev_valid), 32'd0);
            check_eq("no_busy", 32'(busy), 32'd0);
        end

        phase = "single";
        ev_ready = 1'b1;
        lines    = 4'hF;
        run(6);
        lines        = 4'b1011;
        first_seen   = 0;
        valid_cycles = 0;
        for (int j = 1; j <= 12; j++) begin
            cycle();
            if (ev_valid) begin
                valid_cycles++;
                if (first_seen == 0) begin
                    first_seen = j;
                    check_eq("id", 32'(ev_id), 32'd2);
                    check_eq("ovf", 32'(ev_ovf), 32'd0);
                end
            end
        end
        check_eq("latency", 32'(first_seen), 32'(SYNC + 2));
        check_eq("width", 32'(valid_cycles), 32'd1);

        phase = "round_robin";
        lines = 4'hF;
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(6);
        lines = 4'h0;
        collect(12);
        check_order("order_a", 0, 1, 2, 3);
        check_eq("idle_a", 32'(ev_valid), 32'd0);
        lines = 4'hF;
        run(6);
        lines = 4'b1101;
        run(8);
        lines = 4'hF;
        run(6);
        lines = 4'h0;
        collect(12);
        check_order("order_b", 2, 3, 0, 1);

        phase = "coalesce";
        lines    = 4'hF;
        ev_ready = 1'b0;
        run(6);
        for (int p = 0; p < 3; p++) begin
            lines = 4'b1101;
            run(3);
            lines = 4'hF;
            run(3);
        end
        run(4);
        check_eq("held_valid", 32'(ev_valid), 32'd1);
        check_eq("held_id", 32'(ev_id), 32'd1);
        check_eq("held_ovf", 32'(ev_ovf), 32'd0);
        ev_ready = 1'b1;
        collect(8);
        check_eq("hs_count", 32'(got_ids.size()), 32'd2);
        if (got_ids.size() >= 2) begin
            check_eq("second_id", 32'(got_ids[1]), 32'd1);
            check_eq("second_ovf", 32'(got_ovfs[1]), 32'd1);
        end
        check_eq("idle", 32'(ev_valid), 32'd0);

        phase = "enable";
        en    = 4'b0111;
        lines = 4'b0111;
        collect(10);
        check_eq("masked", 32'(got_ids.size()), 32'd0);
        en    = 4'hF;
        lines = 4'hF;
        run(6);
        ev_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            lines = 4'b1110;
            run(3);
            lines = 4'hF;
            run(3);
        end
        run(2);
        en = 4'b1110;
        run(3);
        check_eq("kept_valid", 32'(ev_valid), 32'd1);
        check_eq("kept_id", 32'(ev_id), 32'd0);
        ev_ready = 1'b1;
        collect(8);
        check_eq("one_event", 32'(got_ids.size()), 32'd1);
        en = 4'hF;
        run(4);

        phase = "mid_reset";
        ev_ready = 1'b0;
        lines    = 4'b1110;
        run(6);
        lines = 4'b1010;
        run(6);
        check_eq("pre_valid", 32'(ev_valid), 32'd1);
        reset = 1'b0;
        cycle();
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset    = 1'b1;
        ev_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check_eq("quiet", 32'(ev_valid), 32'd0);
        end

        phase = "random";
        lines = 4'hF;
        run(6);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) lines[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) en = 4'hF;
            ev_ready = ($urandom_range(0, 2) != 0);
            reset    = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
